// File: rtl/piece_queue.sv
// Piece queue for a falling-block game: keeps a preview ("next") piece drawn
// from a 16-bit Galois LFSR and a single hold slot that can be swapped with
// the active piece once per spawn.
// Optional feature: define PIECE_BAG_EN to draw with the 7-bag rule (each
// group of seven draws is a permutation of all pieces). Without it, any id
// 0-6 may repeat.
//
// state | meaning
// INIT  | after reset, filling next_piece for the first time
// IDLE  | next_piece valid, accepting spawn/hold requests
// DRAW  | a piece was spawned from next_piece, drawing a replacement
// HOLD  | hold slot swapped with the active piece, old hold piece spawning
module piece_queue #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spawn_req,
   input  logic        hold_req,
   input  logic [2:0]  cur_piece,
   output logic        spawn_valid,
   output logic [2:0]  spawn_piece,
   output logic [15:0] next_map,
   output logic [15:0] hold_map,
   output logic        hold_valid,
   output logic        busy
);

   typedef enum logic [1:0] {INIT, IDLE, DRAW, HOLD} state_t;

   // An all-zero seed would lock the LFSR, so it is forced to 1.
   localparam logic [15:0] LFSR_RST  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   state_t      state, state_nxt;
   logic [15:0] lfsr;
   logic [2:0]  next_piece;
   logic [2:0]  hold_piece;
   logic        hold_allowed;
   logic [2:0]  cand;
   logic [7:0]  cand_onehot;
   logic        filling;
   logic        cand_ok;
   logic        do_spawn;
   logic        do_hold_first;
   logic        do_hold_swap;

   function automatic logic [15:0] piece_rom(input logic [2:0] id);
      case (id)
         3'd0:    piece_rom = 16'h0F00;
         3'd1:    piece_rom = 16'h0660;
         3'd2:    piece_rom = 16'h4E00;
         3'd3:    piece_rom = 16'h6C00;
         3'd4:    piece_rom = 16'hC600;
         3'd5:    piece_rom = 16'h8E00;
         3'd6:    piece_rom = 16'h2E00;
         default: piece_rom = 16'h0000;
      endcase
   endfunction

`ifdef PIECE_BAG_EN
   logic [6:0] bag;
   logic [6:0] bag_set;

   // Candidate qualification with the bag: id 7 and already-drawn ids retry.
   always_comb begin
      cand        = lfsr[2:0];
      cand_onehot = 8'd1 << cand;
      filling     = (state == INIT) || (state == DRAW);
      bag_set     = bag | cand_onehot[6:0];
      cand_ok     = !cand_onehot[7] && ((cand_onehot[6:0] & bag) == 7'd0);
   end

   // Bag mask; clears in the same cycle the seventh distinct piece is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bag <= 7'd0;
      else if (filling && cand_ok)
         bag <= (bag_set == 7'h7F) ? 7'd0 : bag_set;
   end
`else
   // Candidate qualification without the bag: only id 7 retries.
   always_comb begin
      cand        = lfsr[2:0];
      cand_onehot = 8'd1 << cand;
      filling     = (state == INIT) || (state == DRAW);
      cand_ok     = !cand_onehot[7];
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= INIT;
      else
         state <= state_nxt;
   end

   // Next-state decode; spawn wins over hold when both arrive together.
   always_comb begin
      state_nxt     = state;
      do_spawn      = 1'b0;
      do_hold_first = 1'b0;
      do_hold_swap  = 1'b0;
      case (state)
         INIT, DRAW: if (cand_ok) state_nxt = IDLE;
         IDLE: begin
            if (spawn_req) begin
               do_spawn  = 1'b1;
               state_nxt = DRAW;
            end else if (hold_req && hold_allowed) begin
               if (hold_valid) begin
                  do_hold_swap = 1'b1;
                  state_nxt    = HOLD;
               end else begin
                  do_hold_first = 1'b1;
                  state_nxt     = DRAW;
               end
            end
         end
         HOLD:    state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   // Outputs: busy flag and ROM lookups of the registered ids.
   always_comb begin
      busy     = (state != IDLE);
      next_map = piece_rom(next_piece);
      hold_map = hold_valid ? piece_rom(hold_piece) : 16'h0000;
   end

   // Datapath: free-running LFSR, next/hold ids and the registered spawn pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr         <= LFSR_RST;
         next_piece   <= 3'd0;
         hold_piece   <= 3'd0;
         hold_valid   <= 1'b0;
         hold_allowed <= 1'b1;
         spawn_valid  <= 1'b0;
         spawn_piece  <= 3'd0;
      end else begin
         lfsr        <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
         spawn_valid <= do_spawn | do_hold_first | do_hold_swap;
         if (filling && cand_ok)
            next_piece <= cand;
         if (do_spawn || do_hold_first)
            spawn_piece <= next_piece;
         if (do_hold_swap)
            spawn_piece <= hold_piece;
         if (do_hold_first || do_hold_swap) begin
            hold_piece   <= cur_piece;
            hold_allowed <= 1'b0;
         end
         if (do_hold_first)
            hold_valid <= 1'b1;
         if (do_spawn)
            hold_allowed <= 1'b1;
      end
   end

endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue: a transaction-level model (draw list, hold slot,
// spawn pulse) is compared with the DUT every falling edge, plus directed
// scenarios with hand-computed expectations and a randomized phase.
module tb_piece_queue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        spawn_req = 1'b0;
   logic        hold_req = 1'b0;
   logic [2:0]  cur_piece = 3'd0;
   logic        spawn_valid;
   logic [2:0]  spawn_piece;
   logic [15:0] next_map;
   logic [15:0] hold_map;
   logic        hold_valid;
   logic        busy;

   int n_pass = 0;
   int n_total = 0;
   bit cmp_en = 1'b0;
   bit prev_sv = 1'b0;

   piece_queue #(.SEED(16'hACE1)) dut (
      .clk(clk), .rst_n(rst_n), .spawn_req(spawn_req), .hold_req(hold_req),
      .cur_piece(cur_piece), .spawn_valid(spawn_valid), .spawn_piece(spawn_piece),
      .next_map(next_map), .hold_map(hold_map), .hold_valid(hold_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [15:0] rom [0:6] = '{16'h0F00, 16'h0660, 16'h4E00, 16'h6C00,
                              16'hC600, 16'h8E00, 16'h2E00};
   // phase: 0 = needs a new preview piece, 1 = ready, 2 = finishing a swap
   int          m_phase = 0;
   logic [15:0] m_lfsr = 16'hACE1;
   int          m_next = 0, m_hold = 0, m_sp = 0;
   bit          m_hv = 0, m_allow = 1, m_sv = 0;
   int          drawn[$];

   function automatic bit already_drawn(int c);
`ifdef PIECE_BAG_EN
      foreach (drawn[i]) if (drawn[i] == c) return 1'b1;
`endif
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_lfsr = 16'hACE1; m_next = 0; m_hold = 0; m_sp = 0;
         m_hv = 0; m_allow = 1; m_sv = 0; drawn.delete();
      end else begin
         int c;
         m_sv = 0;
         if (m_phase == 0) begin
            c = int'(m_lfsr % 16'd8);
            if (c != 7 && !already_drawn(c)) begin
               m_next = c;
               drawn.push_back(c);
               if (drawn.size() == 7) drawn.delete();
               m_phase = 1;
            end
         end else if (m_phase == 2) begin
            m_phase = 1;
         end else if (spawn_req) begin
            m_sv = 1; m_sp = m_next; m_allow = 1; m_phase = 0;
         end else if (hold_req && m_allow) begin
            m_sv = 1; m_allow = 0;
            if (!m_hv) begin
               m_sp = m_next; m_hold = int'(cur_piece); m_hv = 1; m_phase = 0;
            end else begin
               m_sp = m_hold; m_hold = int'(cur_piece); m_phase = 2;
            end
         end
         if (m_lfsr % 16'd2 == 16'd1) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
         else                         m_lfsr = m_lfsr >> 1;
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("spawn_valid", {15'd0, spawn_valid}, {15'd0, m_sv});
         chk("spawn_piece", {13'd0, spawn_piece}, 16'(m_sp));
         chk("next_map", next_map, rom[m_next]);
         chk("hold_map", hold_map, m_hv ? rom[m_hold] : 16'h0000);
         chk("hold_valid", {15'd0, hold_valid}, {15'd0, m_hv});
         chk("busy", {15'd0, busy}, {15'd0, m_phase != 1});
         chk("no_double_pulse", {15'd0, spawn_valid & prev_sv}, 16'h0000);
      end
      prev_sv = spawn_valid;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500; i++) begin
         if (!busy) return;
         tick();
      end
      chk("wait_idle_timeout", {15'd0, busy}, 16'h0000);
   endtask

   task automatic pulse(input bit s, input bit h, input logic [2:0] cp);
      spawn_req = s; hold_req = h; cur_piece = cp;
      tick();
      spawn_req = 1'b0; hold_req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {15'd0, busy}, 16'h0001);
      chk("rst_hold_valid", {15'd0, hold_valid}, 16'h0000);
      tick(); tick();
      rst_n = 1'b1;
   endtask

   int seq[70];
   logic [15:0] nm;
   logic [6:0]  mask;
   int          cnt;
   bit          hv;

   initial begin
      #1;
      cmp_en = 1'b1;
      // Reset and first fill: ACE1[2:0] = 1 is accepted immediately (O piece).
      do_reset();
      chk("post_rst_next_map", next_map, 16'h0F00);
      chk("post_rst_busy", {15'd0, busy}, 16'h0001);
      tick();
      chk("first_fill_busy", {15'd0, busy}, 16'h0000);
      chk("first_next_map", next_map, 16'h0660);
      chk("first_hold_map", hold_map, 16'h0000);
      chk("first_hold_valid", {15'd0, hold_valid}, 16'h0000);

      // 70 spawns straight from reset: draw groups align with spawn groups.
      for (int k = 0; k < 70; k++) begin
         wait_idle();
         pulse(1'b1, 1'b0, 3'd0);
         seq[k] = int'(spawn_piece);
      end
      chk("seq_first_piece", 16'(seq[0]), 16'h0001);
`ifdef PIECE_BAG_EN
      for (int g = 0; g < 10; g++) begin
         mask = 7'd0;
         for (int j = 0; j < 7; j++) mask |= 7'(1 << seq[g*7+j]);
         chk("bag_permutation", {9'd0, mask}, 16'h007F);
      end
`endif

      // Hold into an empty slot, then a second hold that must be ignored.
      do_reset();
      wait_idle();
      pulse(1'b0, 1'b1, 3'd3);
      chk("hold1_spawn_valid", {15'd0, spawn_valid}, 16'h0001);
      chk("hold1_spawn_piece", {13'd0, spawn_piece}, 16'h0001);
      chk("hold1_hold_map", hold_map, 16'h6C00);
      chk("hold1_hold_valid", {15'd0, hold_valid}, 16'h0001);
      wait_idle();
      pulse(1'b0, 1'b1, 3'd6);
      chk("hold2_ignored_sv", {15'd0, spawn_valid}, 16'h0000);
      chk("hold2_ignored_busy", {15'd0, busy}, 16'h0000);
      chk("hold2_ignored_map", hold_map, 16'h6C00);

      // Swap: after a spawn, hold with cur_piece=5 releases piece 3.
      pulse(1'b1, 1'b0, 3'd0);
      wait_idle();
      nm = rom[m_next];
      pulse(1'b0, 1'b1, 3'd5);
      chk("swap_spawn_valid", {15'd0, spawn_valid}, 16'h0001);
      chk("swap_spawn_piece", {13'd0, spawn_piece}, 16'h0003);
      chk("swap_hold_map", hold_map, 16'h8E00);
      chk("swap_next_unchanged", next_map, nm);
      tick();
      chk("swap_done_busy", {15'd0, busy}, 16'h0000);

      // Spawn and hold together: spawn only.
      pulse(1'b1, 1'b0, 3'd0);
      wait_idle();
      hv = hold_valid;
      pulse(1'b1, 1'b1, 3'd2);
      cnt = int'(spawn_valid);
      for (int i = 0; i < 8; i++) begin
         tick();
         cnt += int'(spawn_valid);
      end
      chk("both_one_pulse", 16'(cnt), 16'h0001);
      chk("both_hold_valid", {15'd0, hold_valid}, {15'd0, hv});
      chk("both_hold_map", hold_map, 16'h8E00);

      // Randomized traffic, including requests while busy.
      for (int i = 0; i < 3000; i++) begin
         spawn_req = ($urandom_range(0, 3) == 0);
         hold_req  = ($urandom_range(0, 3) == 0);
         cur_piece = 3'($urandom_range(0, 6));
         tick();
      end
      spawn_req = 1'b0; hold_req = 1'b0;

      // Reset in the middle of a draw.
      wait_idle();
      spawn_req = 1'b1;
      @(posedge clk);
      #2;
      spawn_req = 1'b0;
      chk("mid_draw_busy", {15'd0, busy}, 16'h0001);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_spawn_valid", {15'd0, spawn_valid}, 16'h0000);
      chk("mid_rst_spawn_piece", {13'd0, spawn_piece}, 16'h0000);
      chk("mid_rst_busy", {15'd0, busy}, 16'h0001);
      chk("mid_rst_hold_valid", {15'd0, hold_valid}, 16'h0000);
      chk("mid_rst_hold_map", hold_map, 16'h0000);
      chk("mid_rst_next_map", next_map, 16'h0F00);
      tick(); tick();
      rst_n = 1'b1;
      wait_idle();
      chk("recover_next_map", next_map, 16'h0660);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 Parameter SEED, default 16'hACE1, SHALL set the LFSR reset value; a value of 16'h0000 SHALL be replaced by 16'h0001.
REQ-002 Clk  input  1  rising-edge system clock; the block SHALL use one clock only.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 spawn_req  input  1  one-cycle request for a new active piece.
REQ-005 hold_req  input  1  one-cycle request to swap the active piece with the hold slot.
REQ-006 cur_piece  input  3  id of the current active piece, sampled on an accepted hold_req.
REQ-007 spawn_valid  output  1  one-cycle pulse; spawn_piece is valid.
REQ-008 spawn_piece  output  3  id of the piece to place on the field.
REQ-009 next_map  output  16  4x4 bitmap of the next piece, row-major; bit 15 is row 0, col 0.
REQ-010 hold_map  output  16  4x4 bitmap of the held piece; 16'h0000 when the hold slot is empty.
REQ-011 hold_valid  output  1  the hold slot is occupied.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Piece ids 0-6 SHALL be I, O, T, S, Z, J, L; ROM maps SHALL be 0F00, 0660, 4E00, 6C00, C600, 8E00, 2E00 (hex).
REQ-014 LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400); it SHALL step every cycle.
REQ-015 FSM states: INIT, IDLE, DRAW, HOLD.
REQ-016 INIT and DRAW: each cycle, candidate = lfsr[2:0].
  - Candidate 7: reject and retry.
  - Candidate already in the bag mask: reject and retry.
  - Otherwise: load next_piece, set its bag bit, go to IDLE.
REQ-017 When the bag mask would become 7'h7F, it SHALL clear to 7'h00 in the same cycle the 7th piece is loaded.
REQ-018 IDLE, spawn_req high: spawn_valid=1 and spawn_piece=next_piece on the next cycle; set hold_allowed=1; go to DRAW.
REQ-019 IDLE, hold_req high, hold_allowed=1, hold slot empty:
  - hold_piece <= cur_piece and hold_valid <= 1.
  - Spawn next_piece as in REQ-018, then go to DRAW.
  - hold_allowed <= 0.
REQ-020 IDLE, hold_req high, hold_allowed=1, hold slot full: go to HOLD.
  - Next cycle: spawn_piece = old hold_piece with spawn_valid=1; hold_piece <= cur_piece; hold_allowed <= 0.
  - Return to IDLE; no draw occurs.
REQ-021 hold_req while hold_allowed=0 SHALL be ignored.
REQ-022 spawn_req and hold_req high together SHALL service spawn only; the hold request is dropped.
REQ-023 Requests arriving while busy=1 SHALL be ignored; no queuing.
REQ-024 next_map and hold_map SHALL be combinational ROM lookups of the registered ids.
REQ-025 spawn_valid SHALL never be high for two consecutive cycles.

Reset
REQ-026 Reset asserted, at any time including mid-DRAW or mid-HOLD, SHALL immediately set:
  - state=INIT, lfsr=SEED, bag mask=0;
  - next_piece=0, hold_piece=0, hold_valid=0, hold_allowed=1;
  - spawn_valid=0, spawn_piece=0, busy=1.
REQ-027 After reset release, the block SHALL fill next_piece before entering IDLE; busy SHALL fall at that point.

Configuration
REQ-028 Macro PIECE_BAG_EN defined: 7-bag rule per REQ-016/017.
REQ-029 Macro PIECE_BAG_EN undefined:
  - Bag mask logic is removed.
  - Only candidate 7 is rejected, so repeats are allowed.
  - All other behaviour is unchanged.

Verification
REQ-030 Reset with SEED=16'hACE1, release, wait for busy=0 -> next_map equals the ROM entry of the first accepted candidate; hold_map=16'h0000; hold_valid=0.
REQ-031 PIECE_BAG_EN, 70 spawn_req each after busy=0 -> every aligned group of 7 spawn_piece values is a permutation of 0-6.
REQ-032 With hold empty, hold_req and cur_piece=3 -> hold_valid=1, hold_map=16'h6C00, one spawn_valid pulse carrying the prior next_piece; a second hold_req before any spawn_req is ignored.
REQ-033 Hold=3 after a spawn_req, then hold_req with cur_piece=5 -> spawn_piece=3 and spawn_valid pulse, hold_map=16'h8E00, next_piece unchanged.
REQ-034 spawn_req and hold_req in the same cycle -> exactly one spawn_valid pulse; hold_valid unchanged.
REQ-035 Reset asserted during DRAW -> all outputs at REQ-026 values within the same cycle; recovery per REQ-027.
